// File: rtl/scroll_rate_pkg.sv
// Shared definitions for the scroller timebase: rate-table limits, the
// rate index type and the elaboration-time half-period calculator.
package scroll_rate_pkg;

  localparam int MAX_RATES  = 8;
  localparam int RATE_IDX_W = $clog2(MAX_RATES);

  typedef logic [RATE_IDX_W-1:0] rate_idx_t;

  // Half-period length of rate k in input-clock cycles:
  // f_input / (2 * f_slow * ratio^k), truncated. Returns 0 when the
  // divisor collapses to 0 so callers can flag the rate as unusable.
  function automatic longint unsigned half_count(input longint unsigned f_input,
                                                 input longint unsigned f_slow,
                                                 input longint unsigned ratio,
                                                 input int              k);
    longint unsigned div;
    div = 64'd2 * f_slow;
    for (int i = 0; i < k; i++) begin
      div = div * ratio;
    end
    if (div == 64'd0) begin
      return 64'd0;
    end
    return f_input / div;
  endfunction

endpackage

// File: rtl/rate_lut.sv
// Combinational ROM of terminal counts (H_k - 1) for every selectable
// scroll rate, built at elaboration. Entries past NUM_RATES read as 0.
module rate_lut
  import scroll_rate_pkg::*;
#(
  parameter int F_INPUT   = 50_000_000,
  parameter int F_SLOW    = 1,
  parameter int RATIO     = 2,
  parameter int NUM_RATES = 4,
  parameter int CNT_W     = 25
) (
  input  rate_idx_t        idx_i,
  output logic [CNT_W-1:0] last_o
);

  logic [CNT_W-1:0] rom [MAX_RATES];

  for (genvar k = 0; k < MAX_RATES; k++) begin : g_rom
    localparam longint unsigned HK = half_count(F_INPUT, F_SLOW, RATIO, k);
    if (k < NUM_RATES) begin : g_used
      if (HK < 1) begin : g_bad
        $error("rate_lut: half-period of rate %0d is below one cycle", k);
      end
      assign rom[k] = CNT_W'(HK - 64'd1);
    end else begin : g_unused
      assign rom[k] = '0;
    end
  end

  // Pure table read; the index is always within the ROM depth.
  assign last_o = rom[idx_i];

endmodule

// File: rtl/scroll_rate_gen.sv
// Multi-rate scroll timebase: divides clk_in into one of NUM_RATES
// geometric rates, producing a 50% square wave (clk_out) and a one-cycle
// enable (tick) on every rising edge of that wave. Rate changes land only
// on half-period wraps so no half-period is ever truncated.
// Optional build macro SCROLL_RATE_GEN_STEP_EN adds single-step ticks
// while paused; without it the step port is ignored.
module scroll_rate_gen
  import scroll_rate_pkg::*;
#(
  parameter int F_INPUT   = 50_000_000,
  parameter int F_SLOW    = 1,
  parameter int RATIO     = 2,
  parameter int NUM_RATES = 4,
  parameter int SEL_W     = (NUM_RATES > 1) ? $clog2(NUM_RATES) : 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel,
  input  logic             pause,
  input  logic             restart,
  input  logic             step,
  output logic             clk_out,
  output logic             tick,
  output logic [SEL_W-1:0] active_sel
);

  // Rate 0 is the slowest, so its half-period sizes the counter.
  localparam longint unsigned H0    = half_count(F_INPUT, F_SLOW, RATIO, 0);
  localparam int              CNT_W = (H0 > 1) ? $clog2(H0) : 1;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_RATES - 1);

  if (NUM_RATES < 1 || NUM_RATES > MAX_RATES) begin : g_bad_rates
    $error("scroll_rate_gen: NUM_RATES must be 1..%0d", MAX_RATES);
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [SEL_W-1:0] act_q, act_d;
  logic [SEL_W-1:0] sel_clamped;
  logic [CNT_W-1:0] last_cnt;
  logic             wrap;
  logic             step_fire;

  rate_lut #(
    .F_INPUT   (F_INPUT),
    .F_SLOW    (F_SLOW),
    .RATIO     (RATIO),
    .NUM_RATES (NUM_RATES),
    .CNT_W     (CNT_W)
  ) u_rate_lut (
    .idx_i  (rate_idx_t'(act_q)),
    .last_o (last_cnt)
  );

`ifdef SCROLL_RATE_GEN_STEP_EN
  logic step_q;

  // Remember last cycle's step so only its rising edge produces a tick.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  assign step_fire = step & ~step_q;
`else
  logic unused_step;

  assign unused_step = step;
  assign step_fire   = 1'b0;
`endif

  // Out-of-range requests fall back to the fastest configured rate.
  always_comb begin
    sel_clamped = sel;
    if (32'(sel) >= 32'(NUM_RATES)) begin
      sel_clamped = LAST_SEL;
    end
  end

  assign wrap = (cnt_q == last_cnt);

  // Next-state: restart beats pause beats counting; sel is only adopted
  // at a wrap or restart, when the counter is back at zero.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    act_d     = act_q;
    tick_d    = 1'b0;
    if (restart) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      act_d     = sel_clamped;
    end else if (pause) begin
      tick_d = step_fire;
    end else if (wrap) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      act_d     = sel_clamped;
      tick_d    = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and registered outputs, cleared by the synchronous reset.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      act_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      act_q     <= act_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign active_sel = act_q;

endmodule

// File: tb/tb_scroll_rate_gen.sv
// Bench for scroll_rate_gen with F_INPUT=40, F_SLOW=1, RATIO=2,
// NUM_RATES=3 (half-periods 20, 10, 5). A table of hand-derived
// checkpoints walks the directed scenarios, then random stimulus runs;
// every cycle is also compared against a behavioural model.
module tb_scroll_rate_gen;

  localparam int F_INPUT   = 40;
  localparam int F_SLOW    = 1;
  localparam int RATIO     = 2;
  localparam int NUM_RATES = 3;

`ifdef SCROLL_RATE_GEN_STEP_EN
  localparam bit STEP_ON = 1'b1;
`else
  localparam bit STEP_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic [1:0] sel    = 2'd0;
  logic       pause  = 1'b0;
  logic       restart = 1'b0;
  logic       step   = 1'b0;
  logic       clk_out;
  logic       tick;
  logic [1:0] active_sel;

  always #5 clk_in = ~clk_in;

  scroll_rate_gen #(
    .F_INPUT   (F_INPUT),
    .F_SLOW    (F_SLOW),
    .RATIO     (RATIO),
    .NUM_RATES (NUM_RATES)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .sel        (sel),
    .pause      (pause),
    .restart    (restart),
    .step       (step),
    .clk_out    (clk_out),
    .tick       (tick),
    .active_sel (active_sel)
  );

  // ---------------- reference model ----------------
  // Tracks cycles remaining in the current half-period, the wave level
  // and the rate in effect, straight from the timing rules.
  int h_tab [NUM_RATES];
  bit m_lvl;
  bit m_tick;
  int m_act;
  int m_left;
  bit m_prev_step;

  function automatic int clamp_sel(input int s);
    return (s >= NUM_RATES) ? NUM_RATES - 1 : s;
  endfunction

  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic model_edge(input bit rst_n, input int s, input bit p,
                            input bit r, input bit st);
    if (!rst_n) begin
      m_lvl = 0; m_tick = 0; m_act = 0; m_left = h_tab[0]; m_prev_step = 0;
    end else begin
      if (r) begin
        m_lvl = 0; m_tick = 0; m_act = clamp_sel(s); m_left = h_tab[m_act];
      end else if (p) begin
        m_tick = STEP_ON && st && !m_prev_step;
      end else begin
        m_left = m_left - 1;
        m_tick = 0;
        if (m_left == 0) begin
          m_lvl  = !m_lvl;
          m_tick = m_lvl;
          m_act  = clamp_sel(s);
          m_left = h_tab[m_act];
        end
      end
      m_prev_step = st;
    end
    exp_q.push_back({m_lvl, m_tick, 2'(m_act)});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_model();
    logic [3:0] exp;
    logic [3:0] got;
    got = {clk_out, tick, active_sel};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL model cyc %0d: scoreboard queue empty, got %b", cyc, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL model cyc %0d: got clk/tick/act %b required %b", cyc, got, exp);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input bit rst_n, input int s, input bit p,
                             input bit r, input bit st);
    reset   = rst_n;
    sel     = 2'(s);
    pause   = p;
    restart = r;
    step    = st;
    @(posedge clk_in);
    model_edge(rst_n, s, p, r, st);
    cyc++;
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst_n;
    int sel;
    bit pause;
    bit restart;
    bit step;
    int n;
    bit e_clk;
    bit e_tick;
    int e_act;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst_n, input int s, input bit p,
                              input bit r, input bit st, input int n,
                              input bit e_clk, input bit e_tick, input int e_act);
    vec_t v;
    v.rst_n = rst_n; v.sel = s; v.pause = p; v.restart = r; v.step = st;
    v.n = n; v.e_clk = e_clk; v.e_tick = e_tick; v.e_act = e_act;
    return v;
  endfunction

  task automatic check_vec(input int idx, input vec_t v);
    logic [3:0] exp;
    logic [3:0] got;
    exp = {v.e_clk, v.e_tick, 2'(v.e_act)};
    got = {clk_out, tick, active_sel};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL vec%0d cyc %0d: got clk/tick/act %b required %b", idx, cyc, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < NUM_RATES; k++) begin
      h_tab[k] = F_INPUT / (2 * F_SLOW * (RATIO ** k));
    end

    //            rst sel pau rst stp  n   clk tick act
    // reset, then steady rate 0 (H=20): ticks at 20, 60, 100
    vecs.push_back(mk(0, 0, 0, 0, 0,  3,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 19,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  1,  1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  1,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 18,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  1,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 20,  1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 40,  1, 1, 0));
    // mid-period switch 0 -> 2 at cycle 7 of a low half
    vecs.push_back(mk(1, 0, 0, 0, 0, 20,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7,  0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0, 12,  0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, 0,  1,  1, 1, 2));
    vecs.push_back(mk(1, 2, 0, 0, 0,  4,  1, 0, 2));
    vecs.push_back(mk(1, 2, 0, 0, 0,  1,  0, 0, 2));
    vecs.push_back(mk(1, 2, 0, 0, 0,  5,  1, 1, 2));
    // clamp: sel=3 lands as rate 2 at the next wrap
    vecs.push_back(mk(1, 1, 0, 0, 0,  5,  0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0, 0,  9,  0, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0, 0,  1,  1, 1, 2));
    // pause 15 cycles at counter 12, wrap 8 cycles after release
    vecs.push_back(mk(1, 0, 0, 0, 0,  5,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 12,  0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 15,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  7,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  1,  1, 1, 0));
    // restart with pause at counter 9 reloads active_sel
    vecs.push_back(mk(1, 0, 0, 0, 0,  9,  1, 0, 0));
    vecs.push_back(mk(1, 2, 1, 1, 0,  1,  0, 0, 2));
    vecs.push_back(mk(1, 2, 0, 0, 0,  5,  1, 1, 2));
    // reset mid-high-phase, then a clean first tick at H
    vecs.push_back(mk(1, 2, 0, 0, 0,  2,  1, 0, 2));
    vecs.push_back(mk(0, 2, 0, 0, 0,  1,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 19,  0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  1,  1, 1, 0));
    // single-step while paused; step held 4 cycles; step when running ignored
    vecs.push_back(mk(1, 0, 1, 0, 0,  3,  1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  1,  1, STEP_ON, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1,  3,  1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0,  2,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 10,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  9,  1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  1,  0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        drive_cycle(vecs[i].rst_n, vecs[i].sel, vecs[i].pause,
                    vecs[i].restart, vecs[i].step);
      end
      check_vec(i, vecs[i]);
    end

    // Hand-written corner: sel change in the very cycle of a wrap is taken.
    // State here: rate 0, clk_out low, 20 cycles into nothing (just wrapped).
    for (int c = 0; c < 19; c++) drive_cycle(1, 0, 0, 0, 0);
    drive_cycle(1, 1, 0, 0, 0);
    checks++;
    if (active_sel !== 2'd1 || tick !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sel cyc %0d: got act %0d tick %b required act 1 tick 1",
               cyc, active_sel, tick);
    end

    // Randomized stimulus against the model.
    for (int c = 0; c < 4000; c++) begin
      drive_cycle($urandom_range(0, 299) != 0,
                  $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 79) == 0,
                  $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
